// File: rtl/idiv_sequential.sv
// Iterative restoring divider: 2*NB-bit dividend / NB-bit divisor, one quotient bit per clock.
// Optional feature macro IDIV_SIGNED_EN: two's-complement operands with an extra FIX cycle.
module idiv_sequential #(
    parameter int NB = 16
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            iStart,
    input  logic [2*NB-1:0] iDividend,
    input  logic [NB-1:0]   iDivisor,
    output logic            oBusy,
    output logic            oDone,
    output logic [NB-1:0]   oQuotient,
    output logic [NB-1:0]   oRemainder,
    output logic            oDivZero,
    output logic            oOverflow
);

    localparam int SW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_step, w_step_nxt;
    // r_p holds the partial remainder, always below the divisor so NB bits suffice between steps.
    logic [NB-1:0]   r_p, w_p_nxt;
    // r_lo shifts dividend bits out at the top while quotient bits shift in at the bottom.
    logic [NB-1:0]   r_lo, w_lo_nxt;
    logic [NB-1:0]   r_div, w_div_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic [NB-1:0]   r_quot, w_quot_nxt;
    logic [NB-1:0]   r_rem, w_rem_nxt;
    logic            r_dz, w_dz_nxt;
    logic            r_ovf, w_ovf_nxt;

    logic [2*NB-1:0] w_dvd_mag;
    logic [NB-1:0]   w_div_mag;
    logic [NB:0]     w_p_sh;
    logic [NB-1:0]   w_p_sub;
    logic [NB-1:0]   w_p_new;
    logic [NB-1:0]   w_q_new;
    logic            w_qbit;

`ifdef IDIV_SIGNED_EN
    logic            r_neg_q, w_neg_q_nxt;
    logic            r_neg_r, w_neg_r_nxt;
    logic [NB-1:0]   w_q_fix;
    logic [NB-1:0]   w_r_fix;
    logic            w_fix_ovf;

    function automatic logic [2*NB-1:0] neg_wide(input logic [2*NB-1:0] v);
        return ~v + {{(2*NB-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [NB-1:0] neg_nb(input logic [NB-1:0] v);
        return ~v + {{(NB-1){1'b0}}, 1'b1};
    endfunction

    assign w_dvd_mag = iDividend[2*NB-1] ? neg_wide(iDividend) : iDividend;
    assign w_div_mag = iDivisor[NB-1] ? neg_nb(iDivisor) : iDivisor;
    assign w_q_fix   = r_neg_q ? neg_nb(r_lo) : r_lo;
    assign w_r_fix   = r_neg_r ? neg_nb(r_p) : r_p;
    // A negative quotient may reach magnitude 2^(NB-1); a positive one must stay below it.
    assign w_fix_ovf = r_neg_q ? (r_lo[NB-1] & (|r_lo[NB-2:0])) : r_lo[NB-1];
`else
    assign w_dvd_mag = iDividend;
    assign w_div_mag = iDivisor;
`endif

    assign w_p_sh  = {r_p, r_lo[NB-1]};
    assign w_qbit  = (w_p_sh >= {1'b0, r_div});
    assign w_p_sub = w_p_sh[NB-1:0] - r_div;
    assign w_p_new = w_qbit ? w_p_sub : w_p_sh[NB-1:0];
    assign w_q_new = {r_lo[NB-2:0], w_qbit};

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_p_nxt     = r_p;
        w_lo_nxt    = r_lo;
        w_div_nxt   = r_div;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dz_nxt    = r_dz;
        w_ovf_nxt   = r_ovf;
`ifdef IDIV_SIGNED_EN
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (iStart) begin
                    w_busy_nxt = 1'b1;
                    w_dz_nxt   = 1'b0;
                    w_ovf_nxt  = 1'b0;
                    w_step_nxt = {SW{1'b0}};
                    w_div_nxt  = w_div_mag;
                    w_p_nxt    = w_dvd_mag[2*NB-1:NB];
                    w_lo_nxt   = w_dvd_mag[NB-1:0];
`ifdef IDIV_SIGNED_EN
                    w_neg_q_nxt = iDividend[2*NB-1] ^ iDivisor[NB-1];
                    w_neg_r_nxt = iDividend[2*NB-1];
`endif
                    if (iDivisor == {NB{1'b0}}) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_dz_nxt    = 1'b1;
                        w_quot_nxt  = {NB{1'b1}};
                        w_rem_nxt   = iDividend[NB-1:0];
                    end else if (w_dvd_mag[2*NB-1:NB] >= w_div_mag) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_ovf_nxt   = 1'b1;
                        w_quot_nxt  = {NB{1'b1}};
                        w_rem_nxt   = {NB{1'b0}};
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                w_p_nxt    = w_p_new;
                w_lo_nxt   = w_q_new;
                w_step_nxt = r_step + {{(SW-1){1'b0}}, 1'b1};
                if (r_step == LAST_STEP) begin
`ifdef IDIV_SIGNED_EN
                    w_state_nxt = S_FIX;
`else
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_quot_nxt  = w_q_new;
                    w_rem_nxt   = w_p_new;
`endif
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
`ifdef IDIV_SIGNED_EN
            S_FIX: begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
                if (w_fix_ovf) begin
                    w_ovf_nxt  = 1'b1;
                    w_quot_nxt = {NB{1'b1}};
                    w_rem_nxt  = {NB{1'b0}};
                end else begin
                    w_quot_nxt = w_q_fix;
                    w_rem_nxt  = w_r_fix;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; asynchronous clear aborts any operation.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_step  <= {SW{1'b0}};
            r_p     <= {NB{1'b0}};
            r_lo    <= {NB{1'b0}};
            r_div   <= {NB{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= {NB{1'b0}};
            r_rem   <= {NB{1'b0}};
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef IDIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_p     <= w_p_nxt;
            r_lo    <= w_lo_nxt;
            r_div   <= w_div_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dz    <= w_dz_nxt;
            r_ovf   <= w_ovf_nxt;
`ifdef IDIV_SIGNED_EN
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
`endif
        end
    end

    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oQuotient  = r_quot;
    assign oRemainder = r_rem;
    assign oDivZero   = r_dz;
    assign oOverflow  = r_ovf;

endmodule
